// File: rtl/vga_pkg.sv
// Shared constants, register map and cursor pixel codes for the VGA cursor overlay.
package vga_pkg;

   localparam int SCREEN_W_DEFAULT = 640;
   localparam int SCREEN_H_DEFAULT = 480;
   localparam int CURSOR_SIZE      = 16;

   // Word indices within the cursor register page
   localparam logic [5:0] CUR_ROW0_IDX = 6'd0;
   localparam logic [5:0] CUR_COLA_IDX = 6'd16;
   localparam logic [5:0] CUR_COLB_IDX = 6'd17;
   localparam logic [5:0] CUR_CTRL_IDX = 6'd18;

   typedef enum logic [1:0] {
      CUR_TRANSP = 2'd0,
      CUR_COLA   = 2'd1,
      CUR_COLB   = 2'd2,
      CUR_INVERT = 2'd3
   } cursor_code_t;

   // Pixel n of a row word lives in bits [2n+1:2n]
   function automatic cursor_code_t code_at(logic [31:0] row_word, logic [3:0] x);
      return cursor_code_t'(row_word[{x, 1'b0} +: 2]);
   endfunction

endpackage

// File: rtl/vga_cursor_overlay_if.sv
// hwregs write bus into the cursor block; writes are single-cycle strobes, no handshake back.
interface vga_cursor_overlay_if;
   logic        hwregs_write;
   logic [7:0]  hwregs_addr;
   logic [31:0] hwregs_wdata;

   modport master (output hwregs_write, output hwregs_addr, output hwregs_wdata);
   modport slave  (input  hwregs_write, input  hwregs_addr, input  hwregs_wdata);
endinterface

// File: rtl/vga_cursor_regs.sv
// Cursor register file: 16 bitmap rows, two colours and control, with a combinational row-read port.
module vga_cursor_regs
   import vga_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   vga_cursor_overlay_if.slave bus,
   input  logic [3:0]          rd_row_i,
   output logic [31:0]         rd_word_o,
   output logic [23:0]         colour_a_o,
   output logic [23:0]         colour_b_o,
   output logic                enable_o,
   output logic [3:0]          hotspot_x_o,
   output logic [3:0]          hotspot_y_o
);

   logic [31:0] bitmap_q [CURSOR_SIZE];
   logic [31:0] bitmap_d [CURSOR_SIZE];
   logic [23:0] colour_a_q, colour_a_d;
   logic [23:0] colour_b_q, colour_b_d;
   logic        enable_q, enable_d;
   logic [3:0]  hot_x_q, hot_x_d;
   logic [3:0]  hot_y_q, hot_y_d;
   logic [5:0]  word_idx;
   logic        addr_lsb_unused;

   assign word_idx        = bus.hwregs_addr[7:2];
   assign addr_lsb_unused = ^bus.hwregs_addr[1:0];

   always_comb begin
      bitmap_d   = bitmap_q;
      colour_a_d = colour_a_q;
      colour_b_d = colour_b_q;
      enable_d   = enable_q;
      hot_x_d    = hot_x_q;
      hot_y_d    = hot_y_q;
      if (bus.hwregs_write) begin
         if (word_idx[5:4] == 2'b00) begin
            bitmap_d[word_idx[3:0]] = bus.hwregs_wdata;
         end else begin
            case (word_idx)
               CUR_COLA_IDX: colour_a_d = bus.hwregs_wdata[23:0];
               CUR_COLB_IDX: colour_b_d = bus.hwregs_wdata[23:0];
               CUR_CTRL_IDX: begin
                  enable_d = bus.hwregs_wdata[0];
                  hot_x_d  = bus.hwregs_wdata[7:4];
                  hot_y_d  = bus.hwregs_wdata[11:8];
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < CURSOR_SIZE; i++) bitmap_q[i] <= '0;
         colour_a_q <= '0;
         colour_b_q <= '0;
         enable_q   <= 1'b0;
         hot_x_q    <= '0;
         hot_y_q    <= '0;
      end else begin
         bitmap_q   <= bitmap_d;
         colour_a_q <= colour_a_d;
         colour_b_q <= colour_b_d;
         enable_q   <= enable_d;
         hot_x_q    <= hot_x_d;
         hot_y_q    <= hot_y_d;
      end
   end

   // Reads see registered state, so a same-cycle write is visible only from the next pixel
   assign rd_word_o   = bitmap_q[rd_row_i];
   assign colour_a_o  = colour_a_q;
   assign colour_b_o  = colour_b_q;
   assign enable_o    = enable_q;
   assign hotspot_x_o = hot_x_q;
   assign hotspot_y_o = hot_y_q;

endmodule

// File: rtl/vga_cursor_overlay.sv
// 16x16 2-bpp hardware cursor compositor on the palette rgb stream, one cycle of latency.
// Build option VGA_CURSOR_INVERT_EN: pixel code 3 inverts the underlying rgb instead of being transparent.
module vga_cursor_overlay
   import vga_pkg::*;
#(
   parameter int SCREEN_W = SCREEN_W_DEFAULT,
   parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
   input  logic                clock,
   input  logic                reset,
   vga_cursor_overlay_if.slave hwregs,
   input  logic                new_frame,
   input  logic                pix_valid,
   input  logic [23:0]         rgb_in,
   input  logic [9:0]          mouse_x,
   input  logic [9:0]          mouse_y,
   output logic [23:0]         rgb_out,
   output logic                rgb_out_valid
);

   localparam logic [9:0] COL_LAST = 10'(SCREEN_W - 1);
   localparam logic [9:0] ROW_LAST = 10'(SCREEN_H - 1);

   logic [9:0]   col_q, col_d, cur_col;
   logic [9:0]   row_q, row_d, cur_row;
   logic         past_q, past_d, cur_past;
   logic [10:0]  org_x_q, org_x_d, org_y_q, org_y_d;
   logic [10:0]  new_org_x, new_org_y, dx, dy;
   logic [23:0]  rgb_out_q, rgb_out_d, pix;
   logic         valid_q;
   logic         hit;
   cursor_code_t code;

   logic [31:0]  row_word;
   logic [23:0]  colour_a, colour_b;
   logic         enable;
   logic [3:0]   hot_x, hot_y;

   vga_cursor_regs u_regs (
      .clock       (clock),
      .reset       (reset),
      .bus         (hwregs),
      .rd_row_i    (dy[3:0]),
      .rd_word_o   (row_word),
      .colour_a_o  (colour_a),
      .colour_b_o  (colour_b),
      .enable_o    (enable),
      .hotspot_x_o (hot_x),
      .hotspot_y_o (hot_y)
   );

   // A new_frame pixel is (0,0) and already uses the origin latched in this same cycle
   always_comb begin
      new_org_x = {1'b0, mouse_x} - {7'd0, hot_x};
      new_org_y = {1'b0, mouse_y} - {7'd0, hot_y};
      cur_col   = new_frame ? '0 : col_q;
      cur_row   = new_frame ? '0 : row_q;
      cur_past  = new_frame ? 1'b0 : past_q;
      org_x_d   = new_frame ? new_org_x : org_x_q;
      org_y_d   = new_frame ? new_org_y : org_y_q;
      dx        = {1'b0, cur_col} - org_x_d;
      dy        = {1'b0, cur_row} - org_y_d;
      hit       = enable && !cur_past && (dx[10:4] == '0) && (dy[10:4] == '0);
      code      = code_at(row_word, dx[3:0]);

      pix = rgb_in;
      if (hit) begin
         case (code)
            CUR_COLA:   pix = colour_a;
            CUR_COLB:   pix = colour_b;
`ifdef VGA_CURSOR_INVERT_EN
            CUR_INVERT: pix = ~rgb_in;
`endif
            default:    pix = rgb_in;
         endcase
      end
   end

   // Raster tracking; past_d marks pixels beyond the last visible line, which pass through
   always_comb begin
      col_d  = cur_col;
      row_d  = cur_row;
      past_d = cur_past;
      if (pix_valid) begin
         if (cur_col == COL_LAST) begin
            col_d = '0;
            if (cur_row == ROW_LAST) past_d = 1'b1;
            else                     row_d  = cur_row + 10'd1;
         end else begin
            col_d = cur_col + 10'd1;
         end
      end
      rgb_out_d = pix_valid ? pix : rgb_out_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         col_q     <= '0;
         row_q     <= '0;
         past_q    <= 1'b0;
         org_x_q   <= '0;
         org_y_q   <= '0;
         rgb_out_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         col_q     <= col_d;
         row_q     <= row_d;
         past_q    <= past_d;
         org_x_q   <= org_x_d;
         org_y_q   <= org_y_d;
         rgb_out_q <= rgb_out_d;
         valid_q   <= pix_valid;
      end
   end

   assign rgb_out       = rgb_out_q;
   assign rgb_out_valid = valid_q;

endmodule
